// File: rtl/picomips_pkg.sv
// ---------------------------------------------------------------------------
// picomips_pkg
// Purpose : shared definitions for the picoMIPS execution datapath.
//           Holds the default widths, the ALU function encoding and the
//           multiply sequencer state encoding.
// Contents:
//   N_DEFAULT, A_SIZE_DEFAULT, R_SIZE_DEFAULT : default parameter widths
//   aluFunc_t                                 : aluFunc operation encoding
//   mulState_t                                : multiply FSM states
//   isMulFunc()                               : true for MUL / MULI
// ---------------------------------------------------------------------------
package picomips_pkg;

  localparam int N_DEFAULT      = 8;
  localparam int A_SIZE_DEFAULT = 3;
  localparam int R_SIZE_DEFAULT = 3;

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_SUB  = 3'b001,
    FN_ADDI = 3'b010,
    FN_SUBI = 3'b011,
    FN_MUL  = 3'b100,
    FN_MULI = 3'b101,
    FN_LDI  = 3'b110,
    FN_MOV  = 3'b111
  } aluFunc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mulState_t;

  function automatic logic isMulFunc(input aluFunc_t fn);
    return (fn == FN_MUL) || (fn == FN_MULI);
  endfunction

endpackage

// File: rtl/exec_datapath_regfile.sv
// ---------------------------------------------------------------------------
// regFile
// Purpose : 2^R_SIZE x N register file. R0 always reads as zero and writes
//           addressed to it are dropped. Two asynchronous read ports, one
//           synchronous write port, and a permanent tap on R1 for the LEDs.
// Ports   :
//   i_clk, i_rst      : clock, asynchronous active-high reset (clears all)
//   i_we, i_waddr,
//   i_wdata           : write port, takes effect on the rising edge
//   i_raddrA/o_rdataA : read port A (combinational)
//   i_raddrB/o_rdataB : read port B (combinational)
//   o_r1Tap           : current contents of R1
// ---------------------------------------------------------------------------
module regFile #(
  parameter int N      = 8,
  parameter int R_SIZE = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [R_SIZE-1:0] i_waddr,
  input  logic [N-1:0]      i_wdata,
  input  logic [R_SIZE-1:0] i_raddrA,
  input  logic [R_SIZE-1:0] i_raddrB,
  output logic [N-1:0]      o_rdataA,
  output logic [N-1:0]      o_rdataB,
  output logic [N-1:0]      o_r1Tap
);

  localparam int DEPTH = 1 << R_SIZE;

  logic [N-1:0] r_regs [DEPTH];

  // Storage array. Entry 0 is cleared by reset and never written, so it
  // stays zero; the read muxes below also force zero for address 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Reads see the stored value only; a write in the same cycle is visible
  // from the following cycle on.
  assign o_rdataA = (i_raddrA == '0) ? '0 : r_regs[i_raddrA];
  assign o_rdataB = (i_raddrB == '0) ? '0 : r_regs[i_raddrB];
  assign o_r1Tap  = r_regs[1];

endmodule

// File: rtl/exec_datapath.sv
// ---------------------------------------------------------------------------
// exec_datapath
// Purpose : execution datapath of the picoMIPS core: register file, single
//           cycle ALU (ADD/SUB/ADDI/SUBI/LDI/MOV) and a multi-cycle signed
//           Q1.(N-1) fractional shift-add multiplier (MUL/MULI).
// Ports   :
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   writeReg    : instruction valid; the result is written to rD
//   aluFunc     : operation select (see picomips_pkg::aluFunc_t)
//   opD, opS    : destination / source register addresses
//   opT         : immediate operand
//   busy        : stall request, holds instruction and PC while high
//   zeroFlag    : registered (written value == 0) of the last write
//   ledOut      : current contents of R1
// ---------------------------------------------------------------------------
import picomips_pkg::*;

module exec_datapath #(
  parameter int N      = N_DEFAULT,
  parameter int A_SIZE = A_SIZE_DEFAULT,
  parameter int R_SIZE = R_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeReg,
  input  logic [A_SIZE-1:0] aluFunc,
  input  logic [R_SIZE-1:0] opD,
  input  logic [R_SIZE-1:0] opS,
  input  logic [N-1:0]      opT,
  output logic              busy,
  output logic              zeroFlag,
  output logic [N-1:0]      ledOut
);

  localparam int CW = $clog2(N + 1);
  localparam logic [2*N-1:0] SAT_LIMIT = (2*N)'(1) << (N - 1);
  localparam logic [N-1:0]   SAT_VALUE = {1'b0, {(N-1){1'b1}}};

  aluFunc_t          w_fn;
  logic              w_isMul;
  logic [N-1:0]      w_rdD;
  logic [N-1:0]      w_rdS;
  logic [N-1:0]      w_aluRes;
  logic [N-1:0]      w_mulB;
  logic [N-1:0]      w_magA;
  logic [N-1:0]      w_magB;
  logic [2*N-1:0]    w_accNext;
  logic [2*N-1:0]    w_prodShift;
  logic [N-1:0]      w_mag;
  logic              w_sat;
  logic [N-1:0]      w_mulRes;
  logic              w_we;
  logic [R_SIZE-1:0] w_waddr;
  logic [N-1:0]      w_wdata;

  mulState_t         r_state;
  mulState_t         w_next;
  logic [2*N-1:0]    r_acc;
  logic [2*N-1:0]    r_mcand;
  logic [N-1:0]      r_mplier;
  logic              r_negate;
  logic [R_SIZE-1:0] r_dest;
  logic [CW-1:0]     r_step;
  logic              r_zero;

  assign w_fn    = aluFunc_t'(aluFunc[2:0]);
  assign w_isMul = isMulFunc(w_fn);

  regFile #(
    .N      (N),
    .R_SIZE (R_SIZE)
  ) u_regFile (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddrA (opD),
    .i_raddrB (opS),
    .o_rdataA (w_rdD),
    .o_rdataB (w_rdS),
    .o_r1Tap  (ledOut)
  );

  // Single-cycle ALU. Additions and subtractions simply wrap at N bits;
  // the multiply codes produce nothing here because the sequencer owns them.
  always_comb begin
    w_aluRes = '0;
    case (w_fn)
      FN_ADD:  w_aluRes = w_rdD + w_rdS;
      FN_SUB:  w_aluRes = w_rdD - w_rdS;
      FN_ADDI: w_aluRes = w_rdD + opT;
      FN_SUBI: w_aluRes = w_rdD - opT;
      FN_LDI:  w_aluRes = opT;
      FN_MOV:  w_aluRes = w_rdS;
      default: w_aluRes = '0;
    endcase
  end

  // Multiplier operand preparation: magnitudes of both operands at issue.
  // The magnitude of the most negative value (0x80 for N=8) is 2^(N-1),
  // which still fits as an unsigned N-bit number.
  assign w_mulB = (w_fn == FN_MULI) ? opT : w_rdS;
  assign w_magA = w_rdD[N-1]  ? -w_rdD  : w_rdD;
  assign w_magB = w_mulB[N-1] ? -w_mulB : w_mulB;

  // One shift-add step, and the final scaling: drop the N-1 fraction bits
  // (truncation of the magnitude, i.e. toward zero), saturate anything that
  // reaches 1.0, then restore the sign.
  assign w_accNext   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prodShift = r_acc >> (N - 1);
  assign w_sat       = (w_prodShift >= SAT_LIMIT);
  assign w_mag       = w_prodShift[N-1:0];
  assign w_mulRes    = w_sat ? SAT_VALUE : (r_negate ? -w_mag : w_mag);

  // Multiply sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Multiply sequencer next-state logic: IDLE -> RUN on a multiply issue,
  // N shift-add cycles in RUN, then one DONE cycle that writes back.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (writeReg && w_isMul)     w_next = ST_RUN;
      ST_RUN:  if (r_step == CW'(N - 1))    w_next = ST_DONE;
      ST_DONE:                              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  // Sequencer outputs: stall and register-file write control. Busy is
  // forced low while reset is asserted so the stall drops immediately.
  always_comb begin
    busy    = 1'b0;
    w_we    = 1'b0;
    w_waddr = opD;
    w_wdata = w_aluRes;
    case (r_state)
      ST_IDLE: begin
        if (writeReg) begin
          if (w_isMul) busy = 1'b1;
          else         w_we = 1'b1;
        end
      end
      ST_RUN: busy = 1'b1;
      ST_DONE: begin
        w_we    = 1'b1;
        w_waddr = r_dest;
        w_wdata = w_mulRes;
      end
      default: busy = 1'b0;
    endcase
    if (rst) busy = 1'b0;
  end

  // Multiplier working registers. Everything the result depends on is
  // captured at the issue cycle, so later changes on opT or the register
  // file cannot disturb a multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_negate <= 1'b0;
      r_dest   <= '0;
      r_step   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (writeReg && w_isMul) begin
            r_acc    <= '0;
            r_mcand  <= (2*N)'(w_magA);
            r_mplier <= w_magB;
            r_negate <= w_rdD[N-1] ^ w_mulB[N-1];
            r_dest   <= opD;
            r_step   <= '0;
          end
        end
        ST_RUN: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_step   <= r_step + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Zero flag follows every completed write, including writes aimed at R0
  // whose data is otherwise discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (w_we) begin
      r_zero <= (w_wdata == '0);
    end
  end

  assign zeroFlag = r_zero;

endmodule

// File: tb/tb_exec_datapath.sv
// ---------------------------------------------------------------------------
// tb_exec_datapath
// Self-checking bench for exec_datapath. Instructions come from a table of
// {instruction, expected ledOut, expected zeroFlag, expected busy cycles};
// the bench acts as the control path, holding each instruction while busy
// is high. Register contents are observed by moving them into R1 (ledOut).
// ---------------------------------------------------------------------------
module tb_exec_datapath;
  import picomips_pkg::*;

  typedef struct {
    logic [2:0] fn;
    logic [2:0] d;
    logic [2:0] s;
    logic [7:0] t;
    logic [7:0] led;
    logic       zero;
    int         busyN;
  } vec_t;

  typedef struct {
    logic [7:0] led;
    logic       zero;
    int         busyN;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       writeReg;
  logic [2:0] aluFunc;
  logic [2:0] opD;
  logic [2:0] opS;
  logic [7:0] opT;
  logic       busy;
  logic       zeroFlag;
  logic [7:0] ledOut;

  int   checkCount = 0;
  int   passCount  = 0;
  int   busyCount  = 0;
  exp_t scoreboard[$];
  vec_t vecTable[$];

  exec_datapath #(
    .N      (8),
    .A_SIZE (3),
    .R_SIZE (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .writeReg (writeReg),
    .aluFunc  (aluFunc),
    .opD      (opD),
    .opS      (opS),
    .opT      (opT),
    .busy     (busy),
    .zeroFlag (zeroFlag),
    .ledOut   (ledOut)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    checkCount++;
    if (got === expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic addVec(input aluFunc_t fn, input int d, input int s, input logic [7:0] t,
                        input logic [7:0] led, input logic zero, input int busyN);
    vec_t v;
    v.fn = fn; v.d = 3'(d); v.s = 3'(s); v.t = t;
    v.led = led; v.zero = zero; v.busyN = busyN;
    vecTable.push_back(v);
  endtask

  // Drive one instruction from a negedge and hold it until the edge at which
  // busy is low; the instruction retires there. Expectations go to the
  // scoreboard at drive time.
  task automatic applyStimulus(input string name, input vec_t v);
    exp_t e;
    logic retired;
    e.led = v.led; e.zero = v.zero; e.busyN = v.busyN;
    scoreboard.push_back(e);
    writeReg = 1'b1; aluFunc = v.fn; opD = v.d; opS = v.s; opT = v.t;
    busyCount = 0;
    retired = 1'b0;
    for (int c = 0; c < 40 && !retired; c++) begin
      #1;
      if (busy) busyCount++;
      else      retired = 1'b1;
      @(negedge clk);
    end
    writeReg = 1'b0;
    checkOutput($sformatf("%s retire", name), 32'(retired), 32'd1);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkScoreboard(input string name);
    exp_t e;
    e = scoreboard.pop_front();
    checkOutput($sformatf("%s ledOut", name), 32'(ledOut), 32'(e.led));
    checkOutput($sformatf("%s zeroFlag", name), 32'(zeroFlag), 32'(e.zero));
    checkOutput($sformatf("%s busyCycles", name), 32'(busyCount), 32'(e.busyN));
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(name, v);
    checkScoreboard(name);
  endtask

  initial begin
    logic done;
    vec_t v;

    // Main instruction table: R1 is the only register visible, so results
    // in other registers are checked by a following MOV R1,Rx.
    addVec(FN_LDI,  1, 0, 8'h05, 8'h05, 1'b0, 0);
    addVec(FN_LDI,  2, 0, 8'h40, 8'h05, 1'b0, 0);
    addVec(FN_LDI,  3, 0, 8'h60, 8'h05, 1'b0, 0);
    addVec(FN_MUL,  2, 3, 8'h00, 8'h05, 1'b0, 9);
    addVec(FN_MOV,  1, 2, 8'h00, 8'h30, 1'b0, 0);
    addVec(FN_LDI,  2, 0, 8'hC0, 8'h30, 1'b0, 0);
    addVec(FN_MULI, 2, 0, 8'h40, 8'h30, 1'b0, 9);
    addVec(FN_MOV,  1, 2, 8'h00, 8'hE0, 1'b0, 0);
    addVec(FN_LDI,  4, 0, 8'h80, 8'hE0, 1'b0, 0);
    addVec(FN_MUL,  4, 4, 8'h00, 8'hE0, 1'b0, 9);
    addVec(FN_MOV,  1, 4, 8'h00, 8'h7F, 1'b0, 0);
    addVec(FN_LDI,  5, 0, 8'h03, 8'h7F, 1'b0, 0);
    addVec(FN_SUB,  0, 5, 8'h00, 8'h7F, 1'b0, 0);
    addVec(FN_MOV,  1, 0, 8'h00, 8'h00, 1'b1, 0);
    addVec(FN_SUBI, 5, 0, 8'h03, 8'h00, 1'b1, 0);
    addVec(FN_LDI,  1, 0, 8'h33, 8'h33, 1'b0, 0);
    addVec(FN_MOV,  1, 5, 8'h00, 8'h00, 1'b1, 0);
    addVec(FN_LDI,  5, 0, 8'h01, 8'h00, 1'b0, 0);
    addVec(FN_ADDI, 5, 0, 8'hFF, 8'h00, 1'b1, 0);
    addVec(FN_MOV,  1, 5, 8'h00, 8'h00, 1'b1, 0);
    addVec(FN_LDI,  6, 0, 8'h70, 8'h00, 1'b0, 0);
    addVec(FN_LDI,  1, 0, 8'h20, 8'h20, 1'b0, 0);
    addVec(FN_ADD,  1, 6, 8'h00, 8'h90, 1'b0, 0);
    addVec(FN_SUB,  1, 6, 8'h00, 8'h20, 1'b0, 0);
    addVec(FN_LDI,  1, 0, 8'hFF, 8'hFF, 1'b0, 0);
    addVec(FN_MULI, 1, 0, 8'h01, 8'h00, 1'b1, 9);
    addVec(FN_LDI,  7, 0, 8'hA0, 8'h00, 1'b0, 0);
    addVec(FN_LDI,  1, 0, 8'h50, 8'h50, 1'b0, 0);
    addVec(FN_MUL,  1, 7, 8'h00, 8'hC4, 1'b0, 9);
    addVec(FN_LDI,  1, 0, 8'h40, 8'h40, 1'b0, 0);

    // Reset with a multiply presented: busy must stay low during reset.
    rst = 1'b1; writeReg = 1'b1; aluFunc = FN_MUL; opD = 3'd2; opS = 3'd3; opT = 8'h00;
    #2;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ledOut", 32'(ledOut), 32'd0);
    checkOutput("reset zeroFlag", 32'(zeroFlag), 32'd0);
    writeReg = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecTable[i]) begin
      runVec($sformatf("vec%0d", i), vecTable[i]);
    end

    // MULI with opT changed right after issue: R1=0x40 * 0x40 -> 0x20.
    writeReg = 1'b1; aluFunc = FN_MULI; opD = 3'd1; opS = 3'd0; opT = 8'h40;
    @(negedge clk);
    opT = 8'h7F;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (!busy) done = 1'b1;
      @(negedge clk);
    end
    writeReg = 1'b0;
    checkOutput("late opT retire", 32'(done), 32'd1);
    checkOutput("late opT result", 32'(ledOut), 32'h20);

    // Reset during the 4th RUN cycle of MUL R2,R3 (R2=0x40, R3=0x60).
    v = '{FN_LDI, 3'd2, 3'd0, 8'h40, 8'h20, 1'b0, 0}; runVec("rr ldi r2", v);
    v = '{FN_LDI, 3'd3, 3'd0, 8'h60, 8'h20, 1'b0, 0}; runVec("rr ldi r3", v);
    v = '{FN_LDI, 3'd1, 3'd0, 8'h11, 8'h11, 1'b0, 0}; runVec("rr ldi r1", v);
    writeReg = 1'b1; aluFunc = FN_MUL; opD = 3'd2; opS = 3'd3; opT = 8'h00;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rr busy in RUN", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rr busy on reset", 32'(busy), 32'd0);
    checkOutput("rr ledOut on reset", 32'(ledOut), 32'd0);
    checkOutput("rr zeroFlag on reset", 32'(zeroFlag), 32'd0);
    writeReg = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("rr ledOut after release", 32'(ledOut), 32'd0);
    checkOutput("rr zeroFlag after release", 32'(zeroFlag), 32'd0);
    checkOutput("rr busy after release", 32'(busy), 32'd0);
    v = '{FN_MOV, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1, 0}; runVec("rr mov r2", v);
    v = '{FN_MOV, 3'd1, 3'd3, 8'h00, 8'h00, 1'b1, 0}; runVec("rr mov r3", v);
    v = '{FN_LDI, 3'd1, 3'd0, 8'h22, 8'h22, 1'b0, 0}; runVec("rr ldi after", v);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
